spi_frame_receiver: RTL and testbench

- Receiving end of the DAC-style serial link (sync / mosi / sclk) driven by the tone SPI master.
- Oversamples the three link lines in the system clock domain and deserializes MSB-first frames of FRAME_BITS bits.
- Measures the spacing between frame starts, which gives the tone period; flags malformed frames.
- Used as a loopback checker on the board and as the bench-side model of the DAC input.

---
 rtl/spi_frame_receiver.sv | 181 ++++++++++++++++++
 tb/tb_spi_frame_receiver.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_receiver.sv
// Receiver for the sync/mosi/sclk DAC link. Oversamples the link lines in the
// clk domain, assembles MSB-first frames, counts good frames, flags malformed
// frames and measures the spacing between frame starts (the tone period).
module spi_frame_receiver #(
    parameter int unsigned FRAME_BITS  = 16,
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter int unsigned PERIOD_W    = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sync,
    input  logic                  mosi,
    input  logic                  sclk,
    output logic [FRAME_BITS-1:0] data_out,
    output logic                  data_valid,
    output logic                  frame_err,
    output logic                  busy,
    output logic [15:0]           frame_cnt,
    output logic [PERIOD_W-1:0]   period_out,
    output logic                  period_valid
);

    localparam int unsigned BIT_CNT_W = $clog2(FRAME_BITS + 1);
    localparam int unsigned TO_W      = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t                 state;
    logic [2:0]             sync_q;
    logic [2:0]             sclk_q;
    logic [1:0]             mosi_q;
    logic [FRAME_BITS-1:0]  shift_reg;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic [TO_W-1:0]        to_cnt;
    logic                   restart_pend;
    logic [PERIOD_W-1:0]    per_cnt;
    logic                   per_seen;

    logic sync_s;
    logic sync_rise;
    logic sclk_fall;
    logic mosi_s;
    logic frame_full;
    logic last_bit;
    logic to_hit;
    logic per_sat;

    // Synchronizer taps and edge strobes; mosi has the same two-stage delay as sclk
    always_comb begin
        sync_s     = sync_q[1];
        sync_rise  = sync_q[1] & ~sync_q[2];
        sclk_fall  = ~sclk_q[1] & sclk_q[2];
        mosi_s     = mosi_q[1];
        frame_full = (bit_cnt == BIT_CNT_W'(FRAME_BITS));
        last_bit   = (bit_cnt == BIT_CNT_W'(FRAME_BITS - 1));
        to_hit     = (to_cnt == TO_W'(TIMEOUT_CYC - 1));
        per_sat    = &per_cnt;
    end

    // Two-flop synchronizers plus an edge-detect stage for sync and sclk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 3'b000;
            sclk_q <= 3'b000;
            mosi_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[1:0], sync};
            sclk_q <= {sclk_q[1:0], sclk};
            mosi_q <= {mosi_q[0], mosi};
        end
    end

    // Frame FSM: arm on sync, shift on sclk falls, complete/abort with registered pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            shift_reg    <= '0;
            bit_cnt      <= '0;
            to_cnt       <= '0;
            restart_pend <= 1'b0;
            data_out     <= '0;
            data_valid   <= 1'b0;
            frame_err    <= 1'b0;
            busy         <= 1'b0;
            frame_cnt    <= 16'd0;
        end else begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (sync_rise) begin
                        state     <= ARMED;
                        shift_reg <= '0;
                        bit_cnt   <= '0;
                        busy      <= 1'b1;
                    end
                end
                ARMED: begin
                    to_cnt       <= '0;
                    restart_pend <= 1'b0;
                    if (!sync_s) begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (frame_full) begin
                        // Word complete: publish it, then restart if a new sync already arrived
                        data_out   <= shift_reg;
                        data_valid <= 1'b1;
                        frame_cnt  <= frame_cnt + 16'd1;
                        if (sync_rise || restart_pend) begin
                            state     <= ARMED;
                            shift_reg <= '0;
                            bit_cnt   <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (sclk_fall) begin
                        shift_reg <= {shift_reg[FRAME_BITS-2:0], mosi_s};
                        bit_cnt   <= bit_cnt + BIT_CNT_W'(1);
                        to_cnt    <= '0;
                        if (sync_rise) begin
                            if (last_bit) begin
                                // Sync lands on the final bit: finish this frame first
                                restart_pend <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= ARMED;
                                shift_reg <= '0;
                                bit_cnt   <= '0;
                            end
                        end
                    end else if (sync_rise) begin
                        frame_err <= 1'b1;
                        state     <= ARMED;
                        shift_reg <= '0;
                        bit_cnt   <= '0;
                    end else if (to_hit) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Frame-start period: saturating counter restarted on each sync rise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_cnt      <= '0;
            per_seen     <= 1'b0;
            period_out   <= '0;
            period_valid <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            if (sync_rise) begin
                per_cnt  <= '0;
                per_seen <= 1'b1;
                if (per_seen) begin
                    period_out   <= per_sat ? per_cnt : per_cnt + PERIOD_W'(1);
                    period_valid <= 1'b1;
                end
            end else if (!per_sat) begin
                per_cnt <= per_cnt + PERIOD_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_spi_frame_receiver.sv
// Directed/randomized bench for spi_frame_receiver with a transaction-level model.
module tb_spi_frame_receiver;

    localparam int unsigned FRAME_BITS  = 16;
    localparam int unsigned TIMEOUT_CYC = 64;
    localparam int unsigned PERIOD_W    = 24;
    localparam int unsigned PER_MAX     = (1 << PERIOD_W) - 1;
    // Raw line change -> two synchronizer stages -> edge-detect cycle registers the fall
    localparam int unsigned FALL_LAT    = 3;
    localparam int unsigned DV_LAT      = 4;
    localparam int unsigned SPACING     = 3552;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  sync = 1'b0;
    logic                  mosi = 1'b0;
    logic                  sclk = 1'b0;
    logic [FRAME_BITS-1:0] data_out;
    logic                  data_valid;
    logic                  frame_err;
    logic                  busy;
    logic [15:0]           frame_cnt;
    logic [PERIOD_W-1:0]   period_out;
    logic                  period_valid;

    spi_frame_receiver #(
        .FRAME_BITS  (FRAME_BITS),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .PERIOD_W    (PERIOD_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sync         (sync),
        .mosi         (mosi),
        .sclk         (sclk),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .frame_err    (frame_err),
        .busy         (busy),
        .frame_cnt    (frame_cnt),
        .period_out   (period_out),
        .period_valid (period_valid)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed events, sampled mid-cycle
    logic [FRAME_BITS-1:0] dv_q[$];
    logic [PERIOD_W-1:0]   pv_q[$];
    int unsigned           err_n = 0;
    int unsigned           err_cyc = 0;
    int unsigned           dv_cyc = 0;

    always @(negedge clk) begin
        if (data_valid) begin
            dv_q.push_back(data_out);
            dv_cyc = cyc;
        end
        if (frame_err) begin
            err_n++;
            err_cyc = cyc;
        end
        if (period_valid) pv_q.push_back(period_out);
    end

    // Reference model state
    logic [FRAME_BITS-1:0] exp_q[$];
    logic [PERIOD_W-1:0]   exp_pv_q[$];
    logic [15:0]           exp_cnt = 16'd0;
    logic [FRAME_BITS-1:0] exp_last = '0;
    int unsigned           exp_err = 0;
    bit                    have_prev = 1'b0;
    int unsigned           prev_sync = 0;
    int unsigned           drop_cyc = 0;

    int unsigned tests = 0;
    int unsigned fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic raise_sync();
        sync = 1'b1;
        if (have_prev) begin
            exp_pv_q.push_back(PERIOD_W'((cyc - prev_sync > PER_MAX) ? PER_MAX : cyc - prev_sync));
        end
        have_prev = 1'b1;
        prev_sync = cyc;
    endtask

    task automatic send_sync();
        raise_sync();
        step();
        step();
        sync = 1'b0;
        repeat (4) step();
    endtask

    task automatic send_bit(input logic b, input bit sync_here);
        sclk = 1'b1;
        mosi = b;
        step();
        sclk = 1'b0;
        if (sync_here) raise_sync();
        drop_cyc = cyc;
        step();
        step();
        if (sync_here) sync = 1'b0;
        step();
    endtask

    task automatic send_bits(input logic [FRAME_BITS-1:0] w, input int n, input bit sync_last);
        for (int i = 0; i < n; i++) begin
            send_bit(w[FRAME_BITS-1-i], sync_last && (i == n - 1));
        end
    endtask

    task automatic good_frame(input logic [FRAME_BITS-1:0] w);
        send_sync();
        send_bits(w, FRAME_BITS, 1'b0);
        exp_q.push_back(w);
        exp_cnt  = exp_cnt + 16'd1;
        exp_last = w;
        repeat (6) step();
    endtask

    task automatic check_frames(input string tag);
        chk({tag, "_dv_count"}, 32'(dv_q.size()), 32'(exp_q.size()));
        while (dv_q.size() > 0 && exp_q.size() > 0) begin
            chk({tag, "_dv_data"}, 32'(dv_q.pop_front()), 32'(exp_q.pop_front()));
        end
        dv_q.delete();
        exp_q.delete();
        chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_cnt));
        chk({tag, "_data_out"}, 32'(data_out), 32'(exp_last));
        chk({tag, "_err_count"}, err_n, exp_err);
    endtask

    task automatic check_periods(input string tag);
        chk({tag, "_pv_count"}, 32'(pv_q.size()), 32'(exp_pv_q.size()));
        while (pv_q.size() > 0 && exp_pv_q.size() > 0) begin
            chk({tag, "_pv_value"}, 32'(pv_q.pop_front()), 32'(exp_pv_q.pop_front()));
        end
        pv_q.delete();
        exp_pv_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_data_out"}, 32'(data_out), 32'd0);
        chk({tag, "_data_valid"}, 32'(data_valid), 32'd0);
        chk({tag, "_frame_err"}, 32'(frame_err), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
        chk({tag, "_period_out"}, 32'(period_out), 32'd0);
        chk({tag, "_period_valid"}, 32'(period_valid), 32'd0);
    endtask

    initial begin
        logic [FRAME_BITS-1:0] w;
        int unsigned cnt_before;

        // Reset state
        repeat (3) step();
        check_all_zero("reset");
        rst_n = 1'b1;
        step();

        // Single good frame with latency check
        send_sync();
        chk("armed_busy", 32'(busy), 32'd1);
        good_frame_tail: begin
            send_bits(16'hA5C3, FRAME_BITS, 1'b0);
            exp_q.push_back(16'hA5C3);
            exp_cnt  = exp_cnt + 16'd1;
            exp_last = 16'hA5C3;
            repeat (6) step();
        end
        chk("dv_latency", dv_cyc - drop_cyc, DV_LAT);
        chk("idle_busy", 32'(busy), 32'd0);
        check_frames("single");

        // Random frames, mosi noise between frames, stray sclk edges in IDLE
        for (int k = 0; k < 4; k++) begin
            w = FRAME_BITS'($urandom);
            good_frame(w);
            for (int j = 0; j < 10; j++) begin
                mosi = 1'($urandom);
                step();
            end
            for (int j = 0; j < 3; j++) begin
                sclk = 1'b1;
                step();
                sclk = 1'b0;
                step();
            end
            repeat (4) step();
        end
        check_frames("random");

        // Period measurement: three frame starts SPACING cycles apart
        pv_q.delete();
        exp_pv_q.delete();
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin
                while (cyc < prev_sync + SPACING) step();
            end
            good_frame(FRAME_BITS'($urandom));
        end
        check_periods("period");
        check_frames("period");

        // Early sync after 7 bits aborts, then 0x1234 is received
        send_sync();
        send_bits(FRAME_BITS'($urandom), 7, 1'b0);
        raise_sync();
        exp_err++;
        step();
        step();
        sync = 1'b0;
        repeat (4) step();
        chk("early_data_hold", 32'(data_out), 32'(exp_last));
        chk("early_err", err_n, exp_err);
        send_bits(16'h1234, FRAME_BITS, 1'b0);
        exp_q.push_back(16'h1234);
        exp_cnt  = exp_cnt + 16'd1;
        exp_last = 16'h1234;
        repeat (6) step();
        check_frames("early");

        // Timeout: sclk stops after 10 bits
        send_sync();
        send_bits(FRAME_BITS'($urandom), 10, 1'b0);
        repeat (100) step();
        exp_err++;
        chk("timeout_lat", err_cyc - drop_cyc, FALL_LAT + TIMEOUT_CYC);
        chk("timeout_busy", 32'(busy), 32'd0);
        check_frames("timeout");
        check_periods("mid");

        // Async reset during bit 5
        send_sync();
        send_bits(FRAME_BITS'($urandom), 4, 1'b0);
        sclk = 1'b1;
        mosi = 1'b1;
        step();
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        exp_cnt   = 16'd0;
        exp_last  = '0;
        have_prev = 1'b0;
        step();
        sclk = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        repeat (4) step();
        dv_q.delete();
        exp_q.delete();
        good_frame(16'hFFFF);
        check_frames("after_rst");

        // Counter wrap with back-to-back frames (sync on the final bit)
        force dut.frame_cnt = 16'hFFFF;
        step();
        release dut.frame_cnt;
        step();
        exp_cnt = 16'hFFFF;
        chk("wrap_preset", 32'(frame_cnt), 32'(exp_cnt));
        cnt_before = err_n;
        send_sync();
        w = FRAME_BITS'($urandom);
        send_bits(w, FRAME_BITS, 1'b1);
        exp_q.push_back(w);
        exp_cnt  = exp_cnt + 16'd1;
        exp_last = w;
        repeat (4) step();
        chk("wrap_zero", 32'(frame_cnt), 32'(exp_cnt));
        w = FRAME_BITS'($urandom);
        send_bits(w, FRAME_BITS, 1'b0);
        exp_q.push_back(w);
        exp_cnt  = exp_cnt + 16'd1;
        exp_last = w;
        repeat (6) step();
        chk("b2b_no_err", err_n, cnt_before);
        check_frames("b2b");
        check_periods("end");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
